// File: rtl/decode_queue.sv
// decode_queue: RV32I(+M) decode stage buffering decoded control bundles in a DEPTH-entry FIFO,
// with memory/IO strobes routed late against the execute-stage address.
module decode_queue #(
    parameter int XLEN = 32,
    parameter int DEPTH = 2,
    parameter logic [XLEN-1:0] IO_BASE = 32'hFFFFFC00,
    parameter logic [XLEN-1:0] RAM_LIMIT = 32'h00010000,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_a7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [3:0]      alu_op,
    output logic            alu_src,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            sftmd,
    output logic            jal,
    output logic            jalr,
    output logic            br_en,
    output logic [2:0]      br_type,
    output logic [1:0]      mem_op,
    output logic            illegal,
    input  logic [XLEN-1:0] ex_alu_result,
    output logic            mem_read,
    output logic            mem_write,
    output logic            io_read,
    output logic            io_write,
    output logic            access_fault
);
    localparam int AW = $clog2(DEPTH);
    // funct3 -> alu_op for the base integer ops: add sll slt sltu xor srl or and
    localparam logic [31:0] BASE_OPS = {4'd4, 4'd3, 4'd6, 4'd2, 4'd9, 4'd8, 4'd5, 4'd0};

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [3:0]      alu_op;
        logic            alu_src, reg_write, mem_to_reg, sftmd, jal, jalr, br_en;
        logic [2:0]      br_type;
        logic [1:0]      mem_op;
        logic            illegal, force_io, force_ram;
    } entry_t;

    entry_t d, head;
    entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic push, pop, is_ld, is_st, in_io, in_ram, io_sel, ram_sel;

    assign opc = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];

    always_comb begin
        d = '0;
        d.pc = in_pc;
        d.instr = in_instr;
        case (opc)
            7'b0110011: begin
                d.reg_write = 1'b1;
                d.sftmd = (f3 == 3'b001 || f3 == 3'b101) && f7 != 7'b0000001;
                if (f7 == 7'b0000000) d.alu_op = BASE_OPS[f3*4 +: 4];
                else if (f7 == 7'b0100000 && f3 == 3'b000) d.alu_op = 4'd1;
                else if (f7 == 7'b0100000 && f3 == 3'b101) d.alu_op = 4'd7;
                else if (f7 == 7'b0000001 && ENABLE_M && f3 == 3'b000) d.alu_op = 4'd10;
                else if (f7 == 7'b0000001 && ENABLE_M && f3 == 3'b100) d.alu_op = 4'd11;
                else if (f7 == 7'b0000001 && ENABLE_M && f3 == 3'b110) d.alu_op = 4'd12;
                else d.illegal = 1'b1;
            end
            7'b0010011: begin
                d.reg_write = 1'b1;
                d.alu_src = 1'b1;
                d.sftmd = f3 == 3'b001 || f3 == 3'b101;
                d.alu_op = (f3 == 3'b101 && f7 == 7'b0100000) ? 4'd7 : BASE_OPS[f3*4 +: 4];
                d.illegal = (f3 == 3'b001 && f7 != 7'b0000000) ||
                            (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            7'b0000011: begin
                d.mem_op = 2'b01;
                d.alu_src = 1'b1;
                d.reg_write = 1'b1;
                d.mem_to_reg = 1'b1;
            end
            7'b0100011: begin
                d.mem_op = 2'b10;
                d.alu_src = 1'b1;
            end
            7'b1100011: begin
                d.br_en = 1'b1;
                d.br_type = f3;
                d.illegal = f3[2:1] == 2'b01;
            end
            7'b1101111: begin
                d.jal = 1'b1;
                d.reg_write = 1'b1;
            end
            7'b1100111: begin
                d.jalr = 1'b1;
                d.reg_write = 1'b1;
                d.alu_src = 1'b1;
                d.illegal = f3 != 3'b000;
            end
            7'b0110111, 7'b0010111: begin
                d.alu_op = opc[5] ? 4'd13 : 4'd14;
                d.reg_write = 1'b1;
                d.alu_src = 1'b1;
            end
            7'b1110011: begin
                // ecall becomes a load on the IO path (a7=0) or a store on the RAM path (a7=1)
                d.mem_op = in_a7 ? 2'b10 : 2'b01;
                d.alu_src = 1'b1;
                d.reg_write = !in_a7;
                d.mem_to_reg = !in_a7;
                d.force_io = !in_a7;
                d.force_ram = in_a7;
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d = '0;
            d.pc = in_pc;
            d.instr = in_instr;
            d.illegal = 1'b1;
        end
    end

    assign in_ready = !rst && !count[AW];
    assign out_valid = count != '0;
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= d;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head = out_valid ? mem[rp] : '0;
    assign out_pc = head.pc;
    assign out_instr = head.instr;
    assign alu_op = head.alu_op;
    assign alu_src = head.alu_src;
    assign reg_write = head.reg_write;
    assign mem_to_reg = head.mem_to_reg;
    assign sftmd = head.sftmd;
    assign jal = head.jal;
    assign jalr = head.jalr;
    assign br_en = head.br_en;
    assign br_type = head.br_type;
    assign mem_op = head.mem_op;
    assign illegal = head.illegal;

    assign is_ld = head.mem_op == 2'b01;
    assign is_st = head.mem_op == 2'b10;
    assign in_io = ex_alu_result >= IO_BASE;
    assign in_ram = ex_alu_result < RAM_LIMIT;
    assign io_sel = head.force_io || (!head.force_ram && in_io);
    assign ram_sel = head.force_ram || (!head.force_io && !in_io && in_ram);
    assign io_read = is_ld && io_sel;
    assign mem_read = is_ld && ram_sel;
    assign io_write = is_st && io_sel;
    assign mem_write = is_st && ram_sel;
    assign access_fault = (is_ld || is_st) && !io_sel && !ram_sel;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table vectors, hand sequences and random traffic against a queue-based reference model.
module tb_decode_queue;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, instr;
        logic [3:0]  alu_op;
        logic        alu_src, reg_write, mem_to_reg, sftmd, jal, jalr, br_en;
        logic [2:0]  br_type;
        logic [1:0]  mem_op;
        logic        illegal, mem_read, mem_write, io_read, io_write, access_fault;
    } obs_t;
    typedef struct { logic [31:0] instr, pc; logic a7; } ent_t;
    typedef struct {
        logic [31:0] instr;
        logic        a7;
        logic [31:0] addr;
        logic        m0;
        logic [3:0]  alu_op;
        logic        rw, sft, ill;
        logic [4:0]  strb;
        logic        m2r;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_a7 = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0, ex_alu_result = '0;

    logic rdy1, ov1, asrc1, rw1, m2r1, sft1, jal1, jalr1, bre1, ill1, mr1, mw1, ior1, iow1, af1;
    logic [31:0] pc1, ins1;
    logic [3:0] aop1;
    logic [2:0] brt1;
    logic [1:0] mop1;
    logic rdy0, ov0, asrc0, rw0, m2r0, sft0, jal0, jalr0, bre0, ill0, mr0, mw0, ior0, iow0, af0;
    logic [31:0] pc0, ins0;
    logic [3:0] aop0;
    logic [2:0] brt0;
    logic [1:0] mop0;
    obs_t o1, o0;

    int errors = 0, checks = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    decode_queue #(.ENABLE_M(1'b1)) dut_m (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_instr(in_instr), .in_pc(in_pc), .in_a7(in_a7), .out_valid(ov1), .out_ready(out_ready),
        .out_pc(pc1), .out_instr(ins1), .alu_op(aop1), .alu_src(asrc1), .reg_write(rw1),
        .mem_to_reg(m2r1), .sftmd(sft1), .jal(jal1), .jalr(jalr1), .br_en(bre1), .br_type(brt1),
        .mem_op(mop1), .illegal(ill1), .ex_alu_result(ex_alu_result), .mem_read(mr1),
        .mem_write(mw1), .io_read(ior1), .io_write(iow1), .access_fault(af1)
    );

    decode_queue #(.ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .in_instr(in_instr), .in_pc(in_pc), .in_a7(in_a7), .out_valid(ov0), .out_ready(out_ready),
        .out_pc(pc0), .out_instr(ins0), .alu_op(aop0), .alu_src(asrc0), .reg_write(rw0),
        .mem_to_reg(m2r0), .sftmd(sft0), .jal(jal0), .jalr(jalr0), .br_en(bre0), .br_type(brt0),
        .mem_op(mop0), .illegal(ill0), .ex_alu_result(ex_alu_result), .mem_read(mr0),
        .mem_write(mw0), .io_read(ior0), .io_write(iow0), .access_fault(af0)
    );

    assign o1 = '{ov1, pc1, ins1, aop1, asrc1, rw1, m2r1, sft1, jal1, jalr1, bre1, brt1, mop1,
                  ill1, mr1, mw1, ior1, iow1, af1};
    assign o0 = '{ov0, pc0, ins0, aop0, asrc0, rw0, m2r0, sft0, jal0, jalr0, bre0, brt0, mop0,
                  ill0, mr0, mw0, ior0, iow0, af0};

    // Reference: decode the head entry from the ISA rules, then route by address window.
    function automatic obs_t ref_out(bit v, ent_t e, bit en, logic [31:0] addr);
        obs_t r = '0;
        logic [6:0] op = e.instr[6:0];
        logic [2:0] f3 = e.instr[14:12];
        logic [6:0] f7 = e.instr[31:25];
        logic [3:0] base [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
        bit ok = 1'b1;
        bit ld, st;
        if (!v) return r;
        r.valid = 1'b1;
        r.pc = e.pc;
        r.instr = e.instr;
        case (op)
            7'h33: begin
                r.reg_write = 1'b1;
                if (f7 == 7'h00) begin
                    r.alu_op = base[f3];
                    r.sftmd = f3 == 3'd1 || f3 == 3'd5;
                end else if (f7 == 7'h20 && f3 == 3'd0) r.alu_op = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) begin
                    r.alu_op = 4'd7;
                    r.sftmd = 1'b1;
                end else if (f7 == 7'h01 && en && f3 == 3'd0) r.alu_op = 4'd10;
                else if (f7 == 7'h01 && en && f3 == 3'd4) r.alu_op = 4'd11;
                else if (f7 == 7'h01 && en && f3 == 3'd6) r.alu_op = 4'd12;
                else ok = 1'b0;
            end
            7'h13: begin
                r.reg_write = 1'b1;
                r.alu_src = 1'b1;
                r.alu_op = base[f3];
                r.sftmd = f3 == 3'd1 || f3 == 3'd5;
                if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
                if (f3 == 3'd5 && f7 == 7'h20) r.alu_op = 4'd7;
                else if (f3 == 3'd5 && f7 != 7'h00) ok = 1'b0;
            end
            7'h03: begin r.mem_op = 2'd1; r.alu_src = 1'b1; r.reg_write = 1'b1; r.mem_to_reg = 1'b1; end
            7'h23: begin r.mem_op = 2'd2; r.alu_src = 1'b1; end
            7'h63: begin r.br_en = 1'b1; r.br_type = f3; ok = !(f3 == 3'd2 || f3 == 3'd3); end
            7'h6F: begin r.jal = 1'b1; r.reg_write = 1'b1; end
            7'h67: begin r.jalr = 1'b1; r.reg_write = 1'b1; r.alu_src = 1'b1; ok = f3 == 3'd0; end
            7'h37: begin r.alu_op = 4'd13; r.reg_write = 1'b1; r.alu_src = 1'b1; end
            7'h17: begin r.alu_op = 4'd14; r.reg_write = 1'b1; r.alu_src = 1'b1; end
            7'h73: begin
                r.mem_op = e.a7 ? 2'd2 : 2'd1;
                r.alu_src = 1'b1;
                r.reg_write = !e.a7;
                r.mem_to_reg = !e.a7;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            r = '0;
            r.valid = 1'b1;
            r.pc = e.pc;
            r.instr = e.instr;
            r.illegal = 1'b1;
            return r;
        end
        ld = r.mem_op == 2'd1;
        st = r.mem_op == 2'd2;
        if (op == 7'h73) begin
            r.io_read = !e.a7;
            r.mem_write = e.a7;
        end else if (ld || st) begin
            if (addr >= 32'hFFFFFC00) begin r.io_read = ld; r.io_write = st; end
            else if (addr < 32'h00010000) begin r.mem_read = ld; r.mem_write = st; end
            else r.access_fault = 1'b1;
        end
        return r;
    endfunction

    task automatic cmp(string n, logic [127:0] got, logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, want);
        end
    endtask

    task automatic check_all(string n);
        ent_t e = '{32'h0, 32'h0, 1'b0};
        bit v = q.size() != 0;
        #1;
        if (v) e = q[0];
        cmp({n, "/m"}, 128'(o1), 128'(ref_out(v, e, 1'b1, ex_alu_result)));
        cmp({n, "/nom"}, 128'(o0), 128'(ref_out(v, e, 1'b0, ex_alu_result)));
        cmp({n, "/ready"}, 128'({rdy1, rdy0}), 128'({2{!rst && q.size() < 2}}));
    endtask

    task automatic step();
        bit push = in_valid && !rst && q.size() < 2;
        bit pop = q.size() != 0 && out_ready;
        ent_t e = '{in_instr, in_pc, in_a7};
        @(posedge clk);
        if (rst || flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        #1;
    endtask

    vec_t tbl [15];
    obs_t sel;
    logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h7F};
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h55};
    logic [31:0] addrs [4] = '{32'hFFFFFC00, 32'h00000100, 32'h00020000, 32'h0000FFFF};

    initial begin
        tbl = '{
            '{32'h00A30333, 1'b0, 32'h0,        1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 5'b00000, 1'b0},
            '{32'h0002A303, 1'b0, 32'hFFFFFC00, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 5'b10000, 1'b1},
            '{32'h0002A303, 1'b0, 32'h00000100, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 5'b01000, 1'b1},
            '{32'h0002A303, 1'b0, 32'h00020000, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 5'b00001, 1'b1},
            '{32'h0062A023, 1'b0, 32'hFFFFFC00, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'b00100, 1'b0},
            '{32'h0062A023, 1'b0, 32'h00000100, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'b00010, 1'b0},
            '{32'h0062A023, 1'b0, 32'h00020000, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'b00001, 1'b0},
            '{32'h00000073, 1'b0, 32'h00020000, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 5'b10000, 1'b1},
            '{32'h00000073, 1'b1, 32'h00020000, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5'b00010, 1'b0},
            '{32'h02B50533, 1'b0, 32'h0,        1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 5'b00000, 1'b0},
            '{32'h02B50533, 1'b0, 32'h0,        1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0},
            '{32'h0000007F, 1'b0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 5'b00000, 1'b0},
            '{32'h4032D313, 1'b0, 32'h0,        1'b0, 4'd7,  1'b1, 1'b1, 1'b0, 5'b00000, 1'b0},
            '{32'h02001013, 1'b0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 5'b00000, 1'b0},
            '{32'h00002063, 1'b0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 5'b00000, 1'b0}
        };

        step();
        step();
        rst = 1'b0;
        check_all("reset");
        cmp("reset_zero", 128'(o1), 128'(0));
        cmp("reset_ready", 128'(rdy1), 128'(1));

        foreach (tbl[i]) begin
            in_valid = 1'b1;
            in_instr = tbl[i].instr;
            in_a7 = tbl[i].a7;
            in_pc = 32'h1000 + 32'(i) * 4;
            step();
            in_valid = 1'b0;
            ex_alu_result = tbl[i].addr;
            check_all($sformatf("vec%0d", i));
            sel = tbl[i].m0 ? o0 : o1;
            cmp($sformatf("vec%0d_tbl", i),
                128'({sel.valid, sel.alu_op, sel.reg_write, sel.sftmd, sel.illegal, sel.io_read,
                      sel.mem_read, sel.io_write, sel.mem_write, sel.access_fault, sel.mem_to_reg}),
                128'({1'b1, tbl[i].alu_op, tbl[i].rw, tbl[i].sft, tbl[i].ill, tbl[i].strb, tbl[i].m2r}));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check_all($sformatf("vec%0d_pop", i));
            cmp($sformatf("vec%0d_empty", i), 128'(o1), 128'(0));
        end

        ex_alu_result = 32'h0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_instr = 32'h00100093 + 32'(k) * 32'h80;
            in_pc = 32'h200 + 32'(k) * 4;
            check_all("bb_push");
            step();
        end
        in_valid = 1'b0;
        check_all("bb_full");
        cmp("bb_full_ready", 128'(rdy1), 128'(0));
        cmp("bb_head0", 128'(ins1), 128'(32'h00100093));
        out_ready = 1'b1;
        step();
        check_all("bb_pop1");
        cmp("bb_ready_after_pop", 128'(rdy1), 128'(1));
        cmp("bb_head1", 128'(ins1), 128'(32'h00100113));
        step();
        check_all("bb_pop2");
        cmp("bb_drained", 128'(ov1), 128'(0));
        out_ready = 1'b0;

        in_valid = 1'b1;
        in_instr = 32'h00A30333;
        step();
        step();
        in_instr = 32'h00000073;
        flush = 1'b1;
        check_all("flush_full");
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check_all("flush_after");
        cmp("flush_empty", 128'({ov1, rdy1}), 128'(2'b01));
        step();
        cmp("flush_lost", 128'(ov1), 128'(0));

        in_valid = 1'b1;
        step();
        rst = 1'b1;
        #1;
        cmp("rst_ready_low", 128'({rdy1, rdy0}), 128'(0));
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check_all("rst_after");
        cmp("rst_empty", 128'({ov1, rdy1}), 128'(2'b01));

        for (int n = 0; n < 600; n++) begin
            logic [6:0] op = ops[$urandom_range(0, 10)];
            logic [31:0] w = $urandom;
            if (op == 7'h33) w[31:25] = f7s[$urandom_range(0, 3)];
            if (op == 7'h13 && $urandom_range(0, 1) == 1) w[31:25] = f7s[$urandom_range(0, 3)];
            in_instr = {w[31:7], op};
            in_pc = $urandom;
            in_a7 = 1'($urandom);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 29) == 0;
            ex_alu_result = $urandom_range(0, 4) == 4 ? $urandom : addrs[$urandom_range(0, 3)];
            check_all("rand");
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
